// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit combinational ALU between two requesters. Each port has a
// one-entry response slot drained by valid/ready; arbitration is round-robin or fixed.
module alu_share_arbiter #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [3:0]      req0_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req1_op,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,

    output logic            last_grant
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic            elig0, elig1;
    logic            grant0, grant1;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [3:0]      alu_control;
    logic [ShW-1:0]  shamt;

    logic            rsp0_valid_q, rsp1_valid_q;
    logic [XLEN-1:0] rsp0_result_q, rsp1_result_q;
    logic            last_grant_q;

    // A port may issue when its slot is empty or being drained this cycle.
    assign elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
    assign elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (elig0 && elig1) begin
                // Round-robin: the port that did not win last time goes first.
                if (!ROUND_ROBIN || last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Port 0 drives the ALU whenever port 1 is not granted.
    always_comb begin
        alu_a       = req0_a;
        alu_b       = req0_b;
        alu_control = req0_op;
        if (grant1) begin
            alu_a       = req1_a;
            alu_b       = req1_b;
            alu_control = req1_op;
        end
    end

    assign shamt = alu_b[ShW-1:0];

    // Shared ALU; encoding is {funct7[5], funct3}, unknown codes fall back to add.
    always_comb begin
        alu_result = alu_a + alu_b;
        unique case (alu_control)
            4'b0000: alu_result = alu_a + alu_b;
            4'b1000: alu_result = alu_a - alu_b;
            4'b0001: alu_result = alu_a << shamt;
            4'b0010: alu_result = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            4'b0011: alu_result = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = alu_a >> shamt;
            4'b1101: alu_result = $unsigned($signed(alu_a) >>> shamt);
            4'b0110: alu_result = alu_a | alu_b;
            4'b0111: alu_result = alu_a & alu_b;
            default: alu_result = alu_a + alu_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            last_grant_q  <= 1'b1;
        end else begin
            if (grant0) begin
                rsp0_valid_q  <= 1'b1;
                rsp0_result_q <= alu_result;
            end else if (rsp0_ready) begin
                rsp0_valid_q  <= 1'b0;
            end

            if (grant1) begin
                rsp1_valid_q  <= 1'b1;
                rsp1_result_q <= alu_result;
            end else if (rsp1_ready) begin
                rsp1_valid_q  <= 1'b0;
            end

            if (grant0) begin
                last_grant_q <= 1'b0;
            end else if (grant1) begin
                last_grant_q <= 1'b1;
            end
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Drives a round-robin and a fixed-priority instance with the same directed vectors
// and checks both every cycle against a per-port slot model, plus literal spot checks.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        v0, v1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;

    logic        rr_q0, rr_q1, rr_s0, rr_s1, rr_lg;
    logic [31:0] rr_res0, rr_res1;
    logic        fp_q0, fp_q1, fp_s0, fp_s1, fp_lg;
    logic [31:0] fp_res0, fp_res1;

    alu_share_arbiter #(.ROUND_ROBIN(1'b1), .XLEN(32)) dut_rr (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(rr_q0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
        .rsp0_valid(rr_s0), .rsp0_ready(r0), .rsp0_result(rr_res0),
        .req1_valid(v1), .req1_ready(rr_q1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
        .rsp1_valid(rr_s1), .rsp1_ready(r1), .rsp1_result(rr_res1),
        .last_grant(rr_lg)
    );

    alu_share_arbiter #(.ROUND_ROBIN(1'b0), .XLEN(32)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(fp_q0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
        .rsp0_valid(fp_s0), .rsp0_ready(r0), .rsp0_result(fp_res0),
        .req1_valid(v1), .req1_ready(fp_q1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
        .rsp1_valid(fp_s1), .rsp1_ready(r1), .rsp1_result(fp_res1),
        .last_grant(fp_lg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state, index [dut][port]; dut 0 = round-robin, dut 1 = fixed priority.
    logic        m_val [2][2];
    logic [31:0] m_res [2][2];
    logic        m_lg  [2];
    logic        m_known = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return $unsigned($signed(a) >>> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cycle(input logic rst, input logic [1:0] v,
                         input logic [31:0] ia0, input logic [31:0] ib0, input logic [3:0] iop0,
                         input logic [31:0] ia1, input logic [31:0] ib1, input logic [3:0] iop1,
                         input logic [1:0] rdy);
        logic [1:0]  g [2];
        logic [1:0]  elig;
        logic [1:0]  act_q, act_s;
        logic [31:0] act_r [2];
        logic        act_lg;
        logic [31:0] res [2];
        reset = rst; v0 = v[0]; v1 = v[1]; r0 = rdy[0]; r1 = rdy[1];
        a0 = ia0; b0 = ib0; op0 = iop0; a1 = ia1; b1 = ib1; op1 = iop1;
        res[0] = alu_ref(ia0, ib0, iop0);
        res[1] = alu_ref(ia1, ib1, iop1);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                act_q = {rr_q1, rr_q0}; act_s = {rr_s1, rr_s0};
                act_r[0] = rr_res0; act_r[1] = rr_res1; act_lg = rr_lg;
            end else begin
                act_q = {fp_q1, fp_q0}; act_s = {fp_s1, fp_s0};
                act_r[0] = fp_res0; act_r[1] = fp_res1; act_lg = fp_lg;
            end
            g[d] = 2'b00;
            if (!rst) begin
                for (int p = 0; p < 2; p++)
                    elig[p] = v[p] && (!(m_known && m_val[d][p]) || rdy[p]);
                if (elig == 2'b11) g[d] = (d == 1 || m_lg[d]) ? 2'b01 : 2'b10;
                else g[d] = elig;
            end
            cmp($sformatf("ready[dut%0d]", d), {30'd0, act_q}, {30'd0, g[d]});
            if (m_known) begin
                for (int p = 0; p < 2; p++) begin
                    cmp($sformatf("rsp%0d_valid[dut%0d]", p, d), {31'd0, act_s[p]},
                        {31'd0, m_val[d][p]});
                    cmp($sformatf("rsp%0d_result[dut%0d]", p, d), act_r[p], m_res[d][p]);
                end
                cmp($sformatf("last_grant[dut%0d]", d), {31'd0, act_lg}, {31'd0, m_lg[d]});
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int p = 0; p < 2; p++) begin
                    m_val[d][p] = 1'b0;
                    m_res[d][p] = 32'd0;
                end
                m_lg[d] = 1'b1;
            end else if (m_known) begin
                for (int p = 0; p < 2; p++) begin
                    if (g[d][p]) begin
                        m_val[d][p] = 1'b1;
                        m_res[d][p] = res[p];
                        m_lg[d] = (p == 1);
                    end else if (rdy[p]) begin
                        m_val[d][p] = 1'b0;
                    end
                end
            end
        end
        if (rst) m_known = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] rdy);
        cycle(1'b0, 2'b00, 0, 0, 4'd0, 0, 0, 4'd0, rdy);
    endtask

    task automatic rst_cycle(input logic [1:0] v, input logic [1:0] rdy);
        cycle(1'b1, v, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, rdy);
    endtask

    initial begin
        reset = 1'b1; v0 = 0; v1 = 0; r0 = 0; r1 = 0;
        a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
        @(negedge clk);
        rst_cycle(2'b00, 2'b00);
        rst_cycle(2'b00, 2'b00);
        cmp("reset_lg", {31'd0, rr_lg}, 32'd1);
        cmp("reset_res0", rr_res0, 32'd0);

        // Single add on port 0.
        cycle(1'b0, 2'b01, 32'd5, 32'd3, 4'b0000, 0, 0, 4'd0, 2'b11);
        cmp("single_valid0", {31'd0, rr_s0}, 32'd1);
        cmp("single_result0", rr_res0, 32'd8);
        cmp("single_valid1", {31'd0, rr_s1}, 32'd0);
        idle(2'b11);

        // Contention with both consumers always ready.
        rst_cycle(2'b00, 2'b00);
        cycle(1'b0, 2'b11, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 2'b11);
        cmp("rr_first_grant", {31'd0, rr_lg}, 32'd0);
        cmp("rr_sub", rr_res0, 32'd6);
        cycle(1'b0, 2'b11, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 2'b11);
        cmp("rr_second_grant", {31'd0, rr_lg}, 32'd1);
        cmp("rr_xor", rr_res1, 32'hFF);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 2'b11, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 2'b11);
        cmp("fp_always_port0", {31'd0, fp_lg}, 32'd0);
        cmp("fp_port1_starved", {31'd0, fp_s1}, 32'd0);
        cycle(1'b0, 2'b10, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 2'b11);
        cmp("fp_port1_after_drop", fp_res1, 32'hFF);
        idle(2'b11);

        // Back-pressure on port 0 must not block port 1.
        rst_cycle(2'b00, 2'b00);
        cycle(1'b0, 2'b01, 32'd1, 32'd2, 4'b0000, 0, 0, 4'd0, 2'b00);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 2'b11, 32'd7, 32'd7, 4'b0000, i, 32'd1, 4'b0000, 2'b10);
        cmp("bp_hold_valid0", {31'd0, rr_s0}, 32'd1);
        cmp("bp_hold_result0", rr_res0, 32'd3);
        cmp("bp_port1_flow", rr_res1, 32'd4);
        cycle(1'b0, 2'b11, 32'd7, 32'd7, 4'b0000, 32'd9, 32'd1, 4'b0000, 2'b11);
        cmp("bp_refill_valid0", {31'd0, rr_s0}, 32'd1);
        cmp("bp_refill_result0", rr_res0, 32'd14);
        idle(2'b11);
        idle(2'b11);

        // Signed compare and shifts on port 1.
        cycle(1'b0, 2'b10, 0, 0, 4'd0, 32'h8000_0000, 32'd4, 4'b1101, 2'b11);
        cmp("sra", rr_res1, 32'hF800_0000);
        cycle(1'b0, 2'b10, 0, 0, 4'd0, 32'h8000_0000, 32'd4, 4'b0101, 2'b11);
        cmp("srl", rr_res1, 32'h0800_0000);
        cycle(1'b0, 2'b10, 0, 0, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 2'b11);
        cmp("slt", rr_res1, 32'd1);
        cycle(1'b0, 2'b10, 0, 0, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'b0011, 2'b11);
        cmp("sltu", rr_res1, 32'd0);
        cycle(1'b0, 2'b10, 0, 0, 4'd0, 32'd6, 32'd3, 4'b1111, 2'b11);
        cmp("undef_op_add", rr_res1, 32'd9);
        idle(2'b11);

        // Reset in the middle of traffic with both slots full.
        cycle(1'b0, 2'b11, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 2'b00);
        cycle(1'b0, 2'b11, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 2'b00);
        cmp("mid_full0", {31'd0, rr_s0}, 32'd1);
        cmp("mid_full1", {31'd0, rr_s1}, 32'd1);
        rst_cycle(2'b11, 2'b00);
        cmp("mid_rst_valid0", {31'd0, rr_s0}, 32'd0);
        cmp("mid_rst_valid1", {31'd0, fp_s1}, 32'd0);
        cmp("mid_rst_result1", rr_res1, 32'd0);
        cycle(1'b0, 2'b11, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 2'b11);
        cmp("post_rst_grant0", {31'd0, rr_lg}, 32'd0);
        cycle(1'b0, 2'b11, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 2'b11);
        idle(2'b11);
        idle(2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
